// File: rtl/bus_pkg.sv
// Shared bus definitions for the system-bus arbiter and related blocks.
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // One master's view of the bus request channel.
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] address;
        logic                  read;
        logic                  write;
        logic [BUS_MASK_W-1:0] mask;
        logic [BUS_DATA_W-1:0] value;
    } bus_req_t;

    // A master is requesting whenever it asks for either direction.
    function automatic logic req_active(bus_req_t r);
        return r.read | r.write;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first requester after 'last', wrapping.
module rr_priority_picker #(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] pick,
    output logic          valid
);

    // Scan last+1, last+2, ... modulo N; lowest offset wins.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        valid = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last) + off) % N;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                pick  = LW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared system bus. The grant is locked for
// a multi-cycle transfer and an optional timeout forces a faulted completion.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*BUS_ADDR_W-1:0] m_address_in,
    input  logic [NUM_MASTERS-1:0]            m_read_in,
    input  logic [NUM_MASTERS-1:0]            m_write_in,
    input  logic [NUM_MASTERS*BUS_MASK_W-1:0] m_write_mask_in,
    input  logic [NUM_MASTERS*BUS_DATA_W-1:0] m_write_value_in,
    output logic [NUM_MASTERS*BUS_DATA_W-1:0] m_read_value_out,
    output logic [NUM_MASTERS-1:0]            m_ready_out,
    output logic [NUM_MASTERS-1:0]            m_fault_out,
    output logic [BUS_ADDR_W-1:0]             address_out,
    output logic                              read_out,
    output logic                              write_out,
    output logic [BUS_MASK_W-1:0]             write_mask_out,
    output logic [BUS_DATA_W-1:0]             write_value_out,
    input  logic [BUS_DATA_W-1:0]             read_value_in,
    input  logic                              ready_in,
    input  logic                              fault_in,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_out
);

    localparam int LW = $clog2(NUM_MASTERS);
    // A zero timeout still needs a one-bit counter so widths stay legal.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);

    arb_state_t    state_q, state_d;
    logic [LW-1:0] last_q, last_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [TW-1:0] timer_q, timer_d;

    bus_req_t [NUM_MASTERS-1:0] reqs;
    logic [NUM_MASTERS-1:0]     req;
    logic [LW-1:0]              pick;
    logic                       pick_valid;

    logic [LW-1:0]         sel;
    logic                  drive;
    logic                  done;
    logic                  done_fault;
    logic [BUS_DATA_W-1:0] done_data;
    bus_req_t              cur;

    // Slice the flat per-master buses into request structs.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign reqs[i].address = m_address_in[BUS_ADDR_W*i +: BUS_ADDR_W];
        assign reqs[i].read    = m_read_in[i];
        assign reqs[i].write   = m_write_in[i];
        assign reqs[i].mask    = m_write_mask_in[BUS_MASK_W*i +: BUS_MASK_W];
        assign reqs[i].value   = m_write_value_in[BUS_DATA_W*i +: BUS_DATA_W];
        assign req[i]          = req_active(reqs[i]);
    end

    rr_priority_picker #(
        .N  (NUM_MASTERS),
        .LW (LW)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // State, round-robin pointer, lock owner and wait timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            last_q  <= LW'(NUM_MASTERS - 1);
            lock_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            timer_q <= timer_d;
        end
    end

    // Arbitration, completion and timeout decisions for this cycle.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_d     = lock_q;
        timer_d    = timer_q;
        sel        = '0;
        drive      = 1'b0;
        done       = 1'b0;
        done_fault = 1'b0;
        done_data  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    sel   = pick;
                    drive = 1'b1;
                    if (ready_in) begin
                        done       = 1'b1;
                        done_fault = fault_in;
                        done_data  = read_value_in;
                        last_d     = pick;
                    end else begin
                        lock_d  = pick;
                        timer_d = TW'(1);
                        state_d = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                sel = lock_q;
                if (!req[lock_q]) begin
                    // Owner abandoned the transfer: release quietly.
                    last_d  = lock_q;
                    state_d = ARB_IDLE;
                end else if (ready_in) begin
                    drive      = 1'b1;
                    done       = 1'b1;
                    done_fault = fault_in;
                    done_data  = read_value_in;
                    last_d     = lock_q;
                    state_d    = ARB_IDLE;
                end else if (TIMEOUT != 0 && timer_q == TIMER_LIMIT) begin
                    // Slave never answered: hand the master a fault.
                    done       = 1'b1;
                    done_fault = 1'b1;
                    last_d     = lock_q;
                    state_d    = ARB_IDLE;
                end else begin
                    drive = 1'b1;
                    if (timer_q != '1) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        // A completion seen while reset is held must not reach the master.
        if (reset) begin
            done       = 1'b0;
            done_fault = 1'b0;
            done_data  = '0;
        end
    end

    assign cur = reqs[sel];

    // System-side bus: selected master's payload, zero when not driving.
    always_comb begin
        address_out     = '0;
        read_out        = 1'b0;
        write_out       = 1'b0;
        write_mask_out  = '0;
        write_value_out = '0;
        if (drive) begin
            address_out     = cur.address;
            read_out        = cur.read;
            write_out       = cur.write;
            write_mask_out  = cur.read ? '0 : cur.mask;
            write_value_out = cur.value;
        end
    end

    assign grant_out = (state_q == ARB_BUSY) ? lock_q : (pick_valid ? pick : '0);

    // Per-master response: only the completing master sees anything.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_resp
        logic hit;
        assign hit            = done && (sel == LW'(i));
        assign m_ready_out[i] = hit;
        assign m_fault_out[i] = hit && done_fault;
        assign m_read_value_out[BUS_DATA_W*i +: BUS_DATA_W] = hit ? done_data : '0;
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against
// a transaction-level reference model of the round-robin arbiter.
module tb_bus_rr_arbiter;

    localparam int N  = 3;
    localparam int TO = 4;
    localparam int LW = $clog2(N);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N*32-1:0]   m_address_in = '0;
    logic [N-1:0]      m_read_in = '0;
    logic [N-1:0]      m_write_in = '0;
    logic [N*4-1:0]    m_write_mask_in = '0;
    logic [N*32-1:0]   m_write_value_in = '0;
    logic [N*32-1:0]   m_read_value_out;
    logic [N-1:0]      m_ready_out;
    logic [N-1:0]      m_fault_out;
    logic [31:0]       address_out;
    logic              read_out;
    logic              write_out;
    logic [3:0]        write_mask_out;
    logic [31:0]       write_value_out;
    logic [31:0]       read_value_in = '0;
    logic              ready_in = 1'b0;
    logic              fault_in = 1'b0;
    logic [LW-1:0]     grant_out;

    bus_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .m_address_in     (m_address_in),
        .m_read_in        (m_read_in),
        .m_write_in       (m_write_in),
        .m_write_mask_in  (m_write_mask_in),
        .m_write_value_in (m_write_value_in),
        .m_read_value_out (m_read_value_out),
        .m_ready_out      (m_ready_out),
        .m_fault_out      (m_fault_out),
        .address_out      (address_out),
        .read_out         (read_out),
        .write_out        (write_out),
        .write_mask_out   (write_mask_out),
        .write_value_out  (write_value_out),
        .read_value_in    (read_value_in),
        .ready_in         (ready_in),
        .fault_in         (fault_in),
        .grant_out        (grant_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, since which cycle, who went last.
    int          owner = -1;
    int          last  = N - 1;
    int          start_cyc = 0;
    int          cyc = 0;
    int          waits[N];
    logic [N-1:0] done_prev = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_master(input int i, input bit r, input bit w, input logic [31:0] a,
                              input logic [3:0] m, input logic [31:0] v);
        m_read_in[i]             = r;
        m_write_in[i]            = w;
        m_address_in[32*i +: 32] = a;
        m_write_mask_in[4*i +: 4] = m;
        m_write_value_in[32*i +: 32] = v;
    endtask

    task automatic clear_master(input int i);
        set_master(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Next requester after l in circular order, -1 if none.
    function automatic int rr_next(input int l, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(l + k) % N]) return (l + k) % N;
        end
        return -1;
    endfunction

    // A transfer of master w ends; nobody may wait more than N-1 other endings.
    task automatic finish(input int w, input logic [N-1:0] reqv);
        chk("fairness", 128'(waits[w] <= N - 1), 128'(1));
        waits[w] = 0;
        for (int j = 0; j < N; j++) begin
            if (j != w && reqv[j]) waits[j]++;
        end
        last = w;
    endtask

    // Evaluate the model for the current inputs and compare all outputs.
    task automatic eval();
        logic [N-1:0]  reqv;
        int            src;
        int            e_grant;
        logic [N-1:0]  e_ready;
        logic [N-1:0]  e_fault;
        logic [N*32-1:0] e_rdata;
        logic [31:0]   e_addr;
        logic [31:0]   e_val;
        logic [3:0]    e_mask;
        logic          e_rd;
        logic          e_wr;
        int            p;
        #3;
        reqv    = m_read_in | m_write_in;
        src     = -1;
        e_grant = 0;
        e_ready = '0;
        e_fault = '0;
        e_rdata = '0;
        for (int j = 0; j < N; j++) if (!reqv[j]) waits[j] = 0;
        if (reset) begin
            chk("rst_ready", 128'(m_ready_out), 128'(0));
            chk("rst_fault", 128'(m_fault_out), 128'(0));
            owner = -1;
            last  = N - 1;
            for (int j = 0; j < N; j++) waits[j] = 0;
            done_prev = '0;
            cyc++;
            return;
        end
        if (owner < 0) begin
            p = rr_next(last, reqv);
            if (p >= 0) begin
                src     = p;
                e_grant = p;
                if (ready_in) begin
                    e_ready[p] = 1'b1;
                    e_fault[p] = fault_in;
                    e_rdata[32*p +: 32] = read_value_in;
                    finish(p, reqv);
                end else begin
                    owner     = p;
                    start_cyc = cyc;
                end
            end
        end else begin
            e_grant = owner;
            if (!reqv[owner]) begin
                finish(owner, reqv);
                owner = -1;
            end else if (ready_in) begin
                src = owner;
                e_ready[owner] = 1'b1;
                e_fault[owner] = fault_in;
                e_rdata[32*owner +: 32] = read_value_in;
                finish(owner, reqv);
                owner = -1;
            end else if (TO != 0 && cyc - start_cyc == TO) begin
                e_ready[owner] = 1'b1;
                e_fault[owner] = 1'b1;
                finish(owner, reqv);
                owner = -1;
            end else begin
                src = owner;
            end
        end
        e_rd   = (src >= 0) ? m_read_in[src]  : 1'b0;
        e_wr   = (src >= 0) ? m_write_in[src] : 1'b0;
        e_addr = (src >= 0) ? m_address_in[32*src +: 32] : 32'h0;
        e_val  = (src >= 0) ? m_write_value_in[32*src +: 32] : 32'h0;
        e_mask = (src >= 0 && !e_rd) ? m_write_mask_in[4*src +: 4] : 4'h0;
        chk("read_out",  128'(read_out),        128'(e_rd));
        chk("write_out", 128'(write_out),       128'(e_wr));
        chk("address",   128'(address_out),     128'(e_addr));
        chk("wmask",     128'(write_mask_out),  128'(e_mask));
        chk("wvalue",    128'(write_value_out), 128'(e_val));
        chk("m_ready",   128'(m_ready_out),     128'(e_ready));
        chk("m_fault",   128'(m_fault_out),     128'(e_fault));
        chk("m_rdata",   128'(m_read_value_out), 128'(e_rdata));
        chk("grant",     128'(grant_out),       128'(e_grant));
        done_prev = e_ready;
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_once();
        eval();
        adv();
    endtask

    int gexp[4] = '{0, 1, 0, 1};

    initial begin
        for (int j = 0; j < N; j++) waits[j] = 0;
        adv();
        // Reset with no traffic, then an idle cycle with everything quiet.
        reset = 1'b1;
        cyc_once();
        reset = 1'b0;
        eval();
        chk("idle_bus", 128'({read_out, write_out, address_out, write_mask_out, write_value_out}), 128'(0));
        adv();

        // Single-cycle read by master 0.
        set_master(0, 1, 0, 32'h0000_1000, 4'hF, 32'h0);
        ready_in = 1; read_value_in = 32'hDEAD_BEEF;
        eval();
        chk("t1_ready", 128'(m_ready_out), 128'(3'b001));
        chk("t1_data",  128'(m_read_value_out[31:0]), 128'(32'hDEAD_BEEF));
        chk("t1_addr",  128'(address_out), 128'(32'h0000_1000));
        adv();
        clear_master(0);

        // Alternating grants between two continuous requesters.
        reset = 1; cyc_once(); reset = 0;
        set_master(0, 1, 0, 32'h100, 4'h0, 32'h0);
        set_master(1, 1, 0, 32'h200, 4'h0, 32'h0);
        ready_in = 1;
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("t2_grant", 128'(grant_out), 128'(gexp[k]));
            adv();
        end
        clear_master(0); clear_master(1);

        // Master 1 write held three cycles; master 0 waits its turn.
        reset = 1; ready_in = 0; cyc_once(); reset = 0;
        set_master(1, 0, 1, 32'h0000_2000, 4'b0011, 32'h1234_5678);
        set_master(2, 0, 0, 32'h0, 4'h0, 32'h0);
        ready_in = 0;
        // Bring master 1 in alone so it holds the lock, then master 0 joins.
        eval(); adv();
        reset = 1; cyc_once(); reset = 0;
        set_master(0, 0, 0, 32'h0, 4'h0, 32'h0);
        // last = N-1 after reset: order 0,1,2 -> only 1 requests, so 1 wins.
        for (int k = 0; k < 3; k++) begin
            ready_in = (k == 2);
            eval();
            chk("t3_grant", 128'(grant_out), 128'(1));
            chk("t3_mask",  128'(write_mask_out), 128'(4'b0011));
            chk("t3_addr",  128'(address_out), 128'(32'h0000_2000));
            adv();
            if (k == 0) set_master(0, 1, 0, 32'h0000_3000, 4'hF, 32'h0);
        end
        clear_master(1);
        ready_in = 1;
        eval();
        chk("t3_m0", 128'(grant_out), 128'(0));
        chk("t3_m0rdy", 128'(m_ready_out), 128'(3'b001));
        adv();
        clear_master(0);

        // Timeout: master 0 reads, no ready ever; master 1 is next.
        reset = 1; ready_in = 0; cyc_once(); reset = 0;
        set_master(0, 1, 0, 32'h0000_4000, 4'hF, 32'h0);
        set_master(1, 1, 0, 32'h0000_5000, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) cyc_once();
        eval();
        chk("t4_ready", 128'(m_ready_out), 128'(3'b001));
        chk("t4_fault", 128'(m_fault_out), 128'(3'b001));
        chk("t4_rd",    128'(read_out), 128'(0));
        adv();
        clear_master(0);
        eval();
        chk("t4_next", 128'(grant_out), 128'(1));
        adv();
        ready_in = 1; cyc_once(); clear_master(1);

        // Faulted write completion on master 1.
        set_master(1, 0, 1, 32'h0000_6000, 4'hC, 32'hCAFE_F00D);
        ready_in = 1; fault_in = 1;
        eval();
        chk("t5_fault", 128'(m_fault_out), 128'(3'b010));
        chk("t5_ready", 128'(m_ready_out), 128'(3'b010));
        adv();
        clear_master(1); fault_in = 0;

        // Abort: locked master drops its request.
        ready_in = 0;
        set_master(2, 1, 0, 32'h0000_7000, 4'hF, 32'h0);
        cyc_once();
        clear_master(2);
        eval();
        chk("abort_rd",  128'(read_out), 128'(0));
        chk("abort_rdy", 128'(m_ready_out), 128'(0));
        adv();

        // Reset while busy: no ready pulse, master 0 wins afterwards.
        set_master(2, 1, 0, 32'h0000_8000, 4'hF, 32'h0);
        cyc_once();
        reset = 1; ready_in = 1;
        eval();
        chk("t6_noready", 128'(m_ready_out), 128'(0));
        adv();
        reset = 0; ready_in = 0;
        set_master(0, 1, 0, 32'h0000_9000, 4'hF, 32'h0);
        eval();
        chk("t6_grant", 128'(grant_out), 128'(0));
        adv();
        ready_in = 1; cyc_once(); clear_master(0);
        cyc_once(); clear_master(2);
        ready_in = 0;

        // Randomized traffic.
        for (int j = 0; j < N; j++) clear_master(j);
        done_prev = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (done_prev[i]) clear_master(i);
                else if (owner == i && (m_read_in[i] | m_write_in[i]) && $urandom_range(0, 19) == 0)
                    clear_master(i);
                if (!(m_read_in[i] | m_write_in[i]) && !done_prev[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        set_master(i, 1, 0, $urandom, 4'($urandom), $urandom);
                    else
                        set_master(i, 0, 1, $urandom, 4'($urandom), $urandom);
                end
            end
            ready_in      = ($urandom_range(0, 9) < 4);
            fault_in      = ($urandom_range(0, 7) == 0);
            read_value_in = $urandom;
            reset         = ($urandom_range(0, 199) == 0);
            cyc_once();
        end
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
